// File: rtl/bcd_ascii_framer_if.sv
// Byte stream between the BCD framer and the UART TX FIFO.
// The master drives data/valid and the slave returns ready.
interface bcd_ascii_framer_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );
endinterface

// File: rtl/bcd_ascii_framer.sv
// Serialises one frame of packed BCD digits as ASCII bytes on a valid/ready stream.
// It can suppress leading zeros, add separators and a suffix, and ends with an optional CR and a terminator.
module bcd_ascii_framer #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter logic [7:0]  TERM_CHAR  = 8'h0A,
  parameter bit          EMIT_CR    = 1'b0,
  parameter logic [7:0]  ERR_CHAR   = 8'h3F
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_start,
  input  logic [4*NUM_DIGITS-1:0]       i_bcd,
  input  logic [NUM_DIGITS-1:0]         i_sep_mask,
  input  logic [7:0]                    i_sep_char,
  input  logic [$clog2(NUM_DIGITS):0]   i_lz_max,
  input  logic                          i_suffix_en,
  input  logic [7:0]                    i_suffix_char,
  bcd_ascii_framer_if.master            o_tx,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_bcd_err
);

  localparam int unsigned CW = $clog2(NUM_DIGITS) + 1;
  localparam int unsigned BW = 4 * NUM_DIGITS;
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_DIGITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SKIP,
    ST_DIGIT,
    ST_SEP,
    ST_SUFFIX,
    ST_CR,
    ST_TERM
  } state_e;

  state_e              state_q, state_d;
  logic [BW-1:0]       bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0] mask_q, mask_d;
  logic [7:0]          sep_q, sep_d;
  logic                sfx_en_q, sfx_en_d;
  logic [7:0]          sfx_q, sfx_d;
  logic [CW-1:0]       lim_q, lim_d;
  logic [CW-1:0]       idx_q, idx_d;
  logic [7:0]          data_q, data_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [3:0]          cur_digit;
  logic [3:0]          next_digit;
  logic                xfer;
  logic                last_digit;
  logic [CW-1:0]       lz_clamped;
  state_e              tail_state;
  logic [7:0]          tail_byte;

  function automatic logic [7:0] ascii_of(input logic [3:0] d);
    return (d > 4'd9) ? ERR_CHAR : (8'h30 + {4'h0, d});
  endfunction

  // The digit under evaluation is always the top nibble; the mask shifts right so bit 0 tracks it.
  assign cur_digit  = bcd_q[BW-1 -: 4];
  assign next_digit = bcd_q[BW-5 -: 4];
  assign xfer       = valid_q & o_tx.ready;
  assign last_digit = (idx_q == LAST_IDX);
  assign lz_clamped = (i_lz_max > LAST_IDX) ? LAST_IDX : i_lz_max;

  // The first byte after the digit section depends on the frame options.
  always_comb begin
    tail_state = ST_TERM;
    tail_byte  = TERM_CHAR;
    if (sfx_en_q) begin
      tail_state = ST_SUFFIX;
      tail_byte  = sfx_q;
    end else if (EMIT_CR) begin
      tail_state = ST_CR;
      tail_byte  = 8'h0D;
    end
  end

  always_comb begin
    state_d  = state_q;
    bcd_d    = bcd_q;
    mask_d   = mask_q;
    sep_d    = sep_q;
    sfx_en_d = sfx_en_q;
    sfx_d    = sfx_q;
    lim_d    = lim_q;
    idx_d    = idx_q;
    data_d   = data_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    err_d    = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          bcd_d    = i_bcd;
          mask_d   = i_sep_mask;
          sep_d    = i_sep_char;
          sfx_en_d = i_suffix_en;
          sfx_d    = i_suffix_char;
          lim_d    = lz_clamped;
          idx_d    = '0;
          err_d    = 1'b0;
          state_d  = ST_SKIP;
        end
      end

      ST_SKIP: begin
        if ((cur_digit == 4'd0) && (idx_q < lim_q)) begin
          bcd_d  = bcd_q << 4;
          mask_d = mask_q >> 1;
          idx_d  = idx_q + 1'b1;
        end else begin
          data_d  = ascii_of(cur_digit);
          valid_d = 1'b1;
          state_d = ST_DIGIT;
        end
      end

      ST_DIGIT: begin
        if (xfer) begin
          if (cur_digit > 4'd9) begin
            err_d = 1'b1;
          end
          if (mask_q[0]) begin
            data_d  = sep_q;
            state_d = ST_SEP;
          end else if (last_digit) begin
            data_d  = tail_byte;
            state_d = tail_state;
          end else begin
            bcd_d   = bcd_q << 4;
            mask_d  = mask_q >> 1;
            idx_d   = idx_q + 1'b1;
            data_d  = ascii_of(next_digit);
            state_d = ST_DIGIT;
          end
        end
      end

      ST_SEP: begin
        if (xfer) begin
          if (last_digit) begin
            data_d  = tail_byte;
            state_d = tail_state;
          end else begin
            bcd_d   = bcd_q << 4;
            mask_d  = mask_q >> 1;
            idx_d   = idx_q + 1'b1;
            data_d  = ascii_of(next_digit);
            state_d = ST_DIGIT;
          end
        end
      end

      ST_SUFFIX: begin
        if (xfer) begin
          if (EMIT_CR) begin
            data_d  = 8'h0D;
            state_d = ST_CR;
          end else begin
            data_d  = TERM_CHAR;
            state_d = ST_TERM;
          end
        end
      end

      ST_CR: begin
        if (xfer) begin
          data_d  = TERM_CHAR;
          state_d = ST_TERM;
        end
      end

      ST_TERM: begin
        if (xfer) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Frame descriptor registers are only meaningful while busy, so they skip reset.
  always_ff @(posedge clk) begin
    bcd_q    <= bcd_d;
    mask_q   <= mask_d;
    sep_q    <= sep_d;
    sfx_en_q <= sfx_en_d;
    sfx_q    <= sfx_d;
    lim_q    <= lim_d;
    idx_q    <= idx_d;
  end

  assign o_tx.data  = data_q;
  assign o_tx.valid = valid_q;
  assign o_busy     = (state_q != ST_IDLE);
  assign o_done     = done_q;
  assign o_bcd_err  = err_q;

endmodule

// File: tb/tb_bcd_ascii_framer.sv
// Directed bench for bcd_ascii_framer: default build plus an EMIT_CR=1 build on shared stimulus.
module tb_bcd_ascii_framer;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [31:0] i_bcd;
  logic [7:0]  i_sep_mask;
  logic [7:0]  i_sep_char;
  logic [3:0]  i_lz_max;
  logic        i_suffix_en;
  logic [7:0]  i_suffix_char;
  logic        i_ready;

  logic a_busy, a_done, a_err;
  logic c_busy, c_done, c_err;

  bcd_ascii_framer_if tx_if ();
  bcd_ascii_framer_if cr_if ();

  assign tx_if.ready = i_ready;
  assign cr_if.ready = i_ready;

  bcd_ascii_framer u_dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_bcd        (i_bcd),
    .i_sep_mask   (i_sep_mask),
    .i_sep_char   (i_sep_char),
    .i_lz_max     (i_lz_max),
    .i_suffix_en  (i_suffix_en),
    .i_suffix_char(i_suffix_char),
    .o_tx         (tx_if),
    .o_busy       (a_busy),
    .o_done       (a_done),
    .o_bcd_err    (a_err)
  );

  bcd_ascii_framer #(.EMIT_CR(1'b1)) u_dut_cr (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_bcd        (i_bcd),
    .i_sep_mask   (i_sep_mask),
    .i_sep_char   (i_sep_char),
    .i_lz_max     (i_lz_max),
    .i_suffix_en  (i_suffix_en),
    .i_suffix_char(i_suffix_char),
    .o_tx         (cr_if),
    .o_busy       (c_busy),
    .o_done       (c_done),
    .o_bcd_err    (c_err)
  );

  always #5 clk = ~clk;

  logic       use_cr;
  logic [7:0] m_data;
  logic       m_valid, m_busy, m_done, m_err;

  assign m_data  = use_cr ? cr_if.data  : tx_if.data;
  assign m_valid = use_cr ? cr_if.valid : tx_if.valid;
  assign m_busy  = use_cr ? c_busy : a_busy;
  assign m_done  = use_cr ? c_done : a_done;
  assign m_err   = use_cr ? c_err  : a_err;

  int checks   = 0;
  int failures = 0;

  logic [7:0] got[$];
  int first_valid, done_k, done_cnt, stall_err, err_at1, busy_at_done;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Starts a frame, then watches the selected DUT until o_done, recording transferred bytes.
  task automatic run_frame(input logic [31:0] bcd, input logic [7:0] mask, input logic [7:0] sep,
                           input logic [3:0] lz, input logic sfx_en, input logic [7:0] sfx,
                           input bit rnd_ready, input int poke_k);
    bit         pend_stall;
    logic [7:0] pend_data;
    bit         rdy;
    int         idle_bad;
    pend_stall = 1'b0;
    pend_data  = 8'h00;
    got.delete();
    first_valid = -1; done_k = -1; done_cnt = 0; stall_err = 0; err_at1 = -1; busy_at_done = -1;
    @(negedge clk);
    i_bcd = bcd; i_sep_mask = mask; i_sep_char = sep; i_lz_max = lz;
    i_suffix_en = sfx_en; i_suffix_char = sfx; i_start = 1'b1; i_ready = 1'b1;
    for (int k = 1; k <= 400 && done_k < 0; k++) begin
      @(negedge clk);
      i_start = (k == poke_k);
      if (k == poke_k) i_bcd = 32'h99999999;
      if (k == 1) err_at1 = int'(m_err);
      if (pend_stall && (!m_valid || m_data != pend_data)) stall_err++;
      if (m_valid && first_valid < 0) first_valid = k;
      if (m_done) begin
        done_cnt++;
        done_k = k;
        busy_at_done = int'(m_busy);
      end
      rdy = rnd_ready ? ($urandom_range(1, 0) == 1) : 1'b1;
      i_ready    = rdy;
      pend_stall = m_valid && !rdy;
      pend_data  = m_data;
      if (m_valid && rdy) got.push_back(m_data);
    end
    i_start = 1'b0;
    i_ready = 1'b1;
    if (done_k < 0) chk("frame_timeout", 32'd0, 32'd1);
    idle_bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (m_valid || m_done || m_busy) idle_bad++;
    end
    chk("idle_after_frame", idle_bad, 0);
  endtask

  task automatic expect_bytes(input string tag, input string s);
    chk({tag, "_len"}, got.size(), s.len());
    for (int i = 0; i < s.len(); i++) begin
      chk($sformatf("%s_b%0d", tag, i), (i < got.size()) ? {24'h0, got[i]} : 32'hFFFFFFFF,
          {24'h0, 8'(s[i])});
    end
    $display("frame %s: %0d bytes, first_valid=%0d done_k=%0d", tag, got.size(), first_valid, done_k);
  endtask

  int dn;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    use_cr = 1'b0;
    rst = 1'b1; i_start = 1'b0; i_bcd = '0; i_sep_mask = '0; i_sep_char = 8'h00;
    i_lz_max = '0; i_suffix_en = 1'b0; i_suffix_char = 8'h00; i_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_busy", m_busy, 0);
    chk("rst_done", m_done, 0);
    chk("rst_err", m_err, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: time format, continuous ready
    run_frame(32'h12345678, 8'h2A, ":", 4'd0, 1'b0, 8'h00, 1'b0, 0);
    expect_bytes("t1", "12:34:56:78\n");
    chk("t1_first_valid", first_valid, 2);
    chk("t1_contiguous", done_k - first_valid, 12);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_busy_at_done", busy_at_done, 0);

    // 2: range format with suppression and suffix
    run_frame(32'h00000400, 8'h20, ".", 4'd7, 1'b1, "m", 1'b0, 0);
    expect_bytes("t2", "4.00m\n");
    chk("t2_first_valid", first_valid, 7);

    // 3: all zeros, suppression limit clamped
    run_frame(32'h00000000, 8'h00, ":", 4'd15, 1'b0, 8'h00, 1'b0, 0);
    expect_bytes("t3", "0\n");
    chk("t3_first_valid", first_valid, 9);
    chk("t3_err", m_err, 0);

    // 4: backpressure
    run_frame(32'h12345678, 8'h2A, ":", 4'd0, 1'b0, 8'h00, 1'b1, 0);
    expect_bytes("t4", "12:34:56:78\n");
    chk("t4_stall_stable", stall_err, 0);
    chk("t4_done_cnt", done_cnt, 1);

    // 5: invalid digit
    run_frame(32'h000000A5, 8'h00, ":", 4'd0, 1'b0, 8'h00, 1'b0, 0);
    expect_bytes("t5", "000000?5\n");
    chk("t5_err_sticky", m_err, 1);

    // 6a: start while busy is ignored; accepted start clears the error flag
    run_frame(32'h12345678, 8'h2A, ":", 4'd0, 1'b0, 8'h00, 1'b0, 5);
    chk("t6_err_clr", err_at1, 0);
    expect_bytes("t6a", "12:34:56:78\n");
    chk("t6a_done_cnt", done_cnt, 1);

    // 6b: reset after the third byte transfer
    @(negedge clk);
    i_bcd = 32'h12345678; i_sep_mask = 8'h2A; i_sep_char = ":"; i_lz_max = 4'd0;
    i_suffix_en = 1'b0; i_ready = 1'b1; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6b_rst_valid", m_valid, 0);
    chk("t6b_rst_busy", m_busy, 0);
    chk("t6b_rst_done", m_done, 0);
    rst = 1'b0;
    dn = 0;
    repeat (20) begin
      @(negedge clk);
      if (m_done || m_valid) dn++;
    end
    chk("t6b_no_term", dn, 0);
    run_frame(32'h12345678, 8'h2A, ":", 4'd0, 1'b0, 8'h00, 1'b0, 0);
    expect_bytes("t6b", "12:34:56:78\n");

    // 6c: CR build
    use_cr = 1'b1;
    run_frame(32'h12345678, 8'h2A, ":", 4'd0, 1'b0, 8'h00, 1'b0, 0);
    expect_bytes("t6c", "12:34:56:78\r\n");
    run_frame(32'h00000400, 8'h20, ".", 4'd7, 1'b1, "m", 1'b0, 0);
    expect_bytes("t6d", "4.00m\r\n");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_ascii_framer.md
Name: bcd_ascii_framer

Overview:
Parametrised successor to the fixed-format UART line sender. It takes one frame of packed BCD digits plus a per-frame format descriptor, and serialises it as ASCII bytes. Supported formatting: leading-zero suppression, a separator character after any digit, an optional suffix, and an optional CR plus a terminator. It sits between the display/sensor BCD sources and the UART TX FIFO, and drives the FIFO through a valid/ready byte stream.

Parameters:
NUM_DIGITS, 8, BCD digits per frame; legal range 2..16.
TERM_CHAR, 8'h0A, terminator byte, always emitted last.
EMIT_CR, 0, when 1 emit 8'h0D immediately before TERM_CHAR.
ERR_CHAR, 8'h3F, byte emitted in place of any digit value greater than 9.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
i_start  in  1  frame request; accepted only when o_busy=0
i_bcd  in  4*NUM_DIGITS  digits, MSB digit (index 0) at top nibble
i_sep_mask  in  NUM_DIGITS  bit k=1: emit i_sep_char after digit k (k=0 is MSB digit)
i_sep_char  in  8  separator byte
i_lz_max  in  $clog2(NUM_DIGITS)+1  maximum leading zeros to suppress
i_suffix_en  in  1  emit i_suffix_char after the last digit
i_suffix_char  in  8  suffix byte
o_data  out  8  ASCII byte
o_valid  out  1  o_data valid
i_ready  in  1  downstream accepts byte (TX FIFO not full)
o_busy  out  1  frame in progress
o_done  out  1  one-cycle pulse on the cycle the terminator transfers
o_bcd_err  out  1  sticky flag: a digit greater than 9 was seen; cleared on next accepted i_start

Behaviour:
- One clock; reset is synchronous and active-high. On rst at a clk edge:
  - state=IDLE
  - o_valid=0, o_data=0, o_busy=0, o_done=0, o_bcd_err=0
  - the in-flight frame is dropped with no terminator.
- Acceptance: i_start=1 with o_busy=0 at edge T.
  - All i_* descriptor inputs and i_bcd are latched.
  - o_busy=1 from T+1.
  - i_start while busy is ignored; the new frame is not queued.
- Effective suppression limit L = min(i_lz_max, NUM_DIGITS-1). The last digit is never suppressed.
- States: IDLE -> SKIP -> DIGIT/SEP (alternating per mask) -> SUFFIX (if enabled) -> CR (if EMIT_CR) -> TERM -> IDLE.
- SKIP: one cycle per evaluated digit.
  - If the current digit is 0 and the suppressed count is less than L: shift the digit register left 4 and increment the count. A separator following a suppressed digit is also suppressed.
  - Otherwise: load the first output byte and go to the DIGIT flow.
  - First o_valid is at T+2+S, where S = number of suppressed digits.
- Digit byte = 8'h30 + digit. A digit greater than 9 emits ERR_CHAR and sets o_bcd_err.
- Stream handshake:
  - A byte transfers on a clk edge with o_valid & i_ready.
  - o_data and o_valid must hold stable while o_valid=1 & i_ready=0.
  - The next byte is loaded in the same edge as a transfer, giving 1 byte/cycle with i_ready held high.
  - o_valid deasserts only after the terminator transfers.
- Frame byte count = (NUM_DIGITS - S) + (separators on unsuppressed digits) + suffix_en + EMIT_CR + 1.
- On the terminator transfer: o_done=1 for one cycle, o_busy=0 from the next cycle, and a new i_start may be accepted that same next cycle.
- Separator after the last digit (mask bit NUM_DIGITS-1) is legal and is emitted before the suffix.

Test Plan:
1. Time format, NUM_DIGITS=8, i_bcd=32'h12345678, mask=8'h2A, sep=':', lz=0, suffix off, i_ready=1 -> bytes "12:34:56:78" then 0x0A, 12 consecutive cycles, single o_done.
2. Range format, i_bcd=32'h00000400, lz=7, mask=8'h20, sep='.', suffix 'm' -> "4.00m\n"; first o_valid at T+7 (S=5).
3. All-zero frame, i_bcd=0, lz=15 (clamped to 7) -> "0\n"; o_bcd_err=0.
4. Backpressure: scenario 1 with i_ready toggling 1-0-0-1 randomly -> o_data stable while stalled, identical byte sequence, no drop or duplicate.
5. Error digit, i_bcd=32'h000000A5, lz=0 -> "000000?5\n"; o_bcd_err=1 after the '?' transfer, stays 1, and clears on the next accepted i_start.
6. Start while busy ignored; rst asserted mid-frame after the 3rd byte -> o_valid=0 the next cycle, no terminator, o_busy=0, the next i_start produces a clean full frame; EMIT_CR=1 build -> 0x0D precedes 0x0A.
